// File: rtl/uart_tx_byte.sv
// uart_tx_byte: byte-wide UART transmitter, 8 data bits LSB first.
// One byte per valid/ready handshake, 1 or 2 stop bits.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          w_tick;
    logic          w_done;

    assign w_tick = (r_timer == TMR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // r_idx counts data bits in DATA and stop bits in STOP
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = i_data;
                    w_idx_nxt   = '0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_idx == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_done      = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_timer_nxt = r_timer + TW'(1);
        if (r_state == S_IDLE || w_state_nxt != r_state || w_tick) begin
            w_timer_nxt = '0;
        end
    end

    // Line level is computed one cycle ahead so o_tx comes straight from a flop
    always_comb begin
        w_tx_nxt = 1'b1;
        unique case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign o_tx    = r_tx;
    assign o_ready = (r_state == S_IDLE);
    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = w_done;

endmodule

// File: tb/tb_uart_tx_byte.sv
// tb_uart_tx_byte: directed and random frames on two configurations,
// checked cycle by cycle against an expected line waveform.
module tb_uart_tx_byte;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data [2];
    logic       valid [2];
    logic       ready [2];
    logic       tx [2];
    logic       busy [2];
    logic       done [2];

    int n_chk = 0;
    int n_err = 0;

    // expected per-cycle {tx, busy, done}
    logic [2:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_byte #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (data[0]),
        .i_valid(valid[0]),
        .o_ready(ready[0]),
        .o_tx   (tx[0]),
        .o_busy (busy[0]),
        .o_done (done[0])
    );

    uart_tx_byte #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (data[1]),
        .i_valid(valid[1]),
        .o_ready(ready[1]),
        .o_tx   (tx[1]),
        .o_busy (busy[1]),
        .o_done (done[1])
    );

    function automatic int cpb_of(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    function automatic int stop_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b100);
    endtask

    // frame = start, 8 data bits LSB first, stop bits; each bit cpb cycles
    task automatic push_frame(input int u, input logic [7:0] b);
        int nb;
        int cpb;
        logic t;
        nb  = 9 + stop_of(u);
        cpb = cpb_of(u);
        for (int k = 0; k < nb; k++) begin
            if (k == 0) t = 1'b0;
            else if (k <= 8) t = b[k-1];
            else t = 1'b1;
            for (int c = 0; c < cpb; c++) begin
                exp_q.push_back({t, 1'b1, (k == nb - 1 && c == cpb - 1)});
            end
        end
    endtask

    task automatic drain(input int u, input int drop_at, input bit glitch);
        logic [2:0] e;
        int i;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx", tx[u], e[2]);
            chk("busy", busy[u], e[1]);
            chk("done", done[u], e[0]);
            chk("ready", ready[u], !e[1]);
            if (i == drop_at) valid[u] = 1'b0;
            if (glitch) begin
                if (i == 10) begin
                    valid[u] = 1'b1;
                    data[u]  = 8'hFF;
                end
                if (i == 12) valid[u] = 1'b0;
                if (i == 20) data[u] = 8'($urandom);
            end
            i++;
            @(negedge clk);
        end
    endtask

    task automatic send(input int u, input logic [7:0] b, input bit glitch);
        data[u]  = b;
        valid[u] = 1'b1;
        push_frame(u, b);
        push_idle(glitch ? 4 : 1);
        @(negedge clk);
        drain(u, 0, glitch);
    endtask

    initial begin
        int u;
        int gap;
        logic [7:0] b;
        rst_n    = 1'b0;
        data[0]  = '0;
        data[1]  = '0;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx", tx[k], 1'b1);
            chk("rst_ready", ready[k], 1'b1);
            chk("rst_busy", busy[k], 1'b0);
            chk("rst_done", done[k], 1'b0);
        end
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            chk("idle_tx0", tx[0], 1'b1);
            chk("idle_tx1", tx[1], 1'b1);
        end

        send(0, 8'h41, 1'b0);
        send(1, 8'hFF, 1'b0);

        data[0]  = 8'h55;
        valid[0] = 1'b1;
        push_frame(0, 8'h55);
        push_idle(1);
        push_frame(0, 8'hAA);
        push_idle(2);
        @(negedge clk);
        data[0] = 8'hAA;
        drain(0, 41, 1'b0);

        send(0, 8'h3C, 1'b1);

        data[0]  = 8'hA5;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_busy", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx[0], 1'b1);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_done", done[0], 1'b0);
        chk("mid_rst_ready", ready[0], 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_done", done[0], 1'b0);
            chk("mid_rst_tx", tx[0], 1'b1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 8'h00, 1'b0);

        for (int n = 0; n < 24; n++) begin
            u   = int'($urandom_range(1, 0));
            b   = 8'($urandom);
            gap = int'($urandom_range(3, 0));
            repeat (gap) begin
                chk("gap_tx", tx[u], 1'b1);
                chk("gap_ready", ready[u], 1'b1);
                @(negedge clk);
            end
            send(u, b, ($urandom_range(2, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- UART transmitter: accepts one byte per valid/ready handshake and serialises it on o_tx as an 8N1 frame (or 8N2).
- Frame order: start bit, 8 data bits LSB first, stop bit(s).
- Transmit-side counterpart to the UART receive path that produces i_data/i_ready_to_read bytes. Drives the board TX pin, which idles high.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- i_data  input  8  byte to send; bit 0 is transmitted first.
- i_valid  input  1  i_data holds a byte to send.
- o_ready  output  1  block can accept a byte this cycle.
- o_tx  output  1  serial line, idle high.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - State IDLE; o_tx=1, o_ready=1, o_busy=0, o_done=0.
  - Shift register and counters cleared.
- Handshake: transfer occurs on a posedge where i_valid=1 and o_ready=1. i_data is latched into an internal shift register at that edge.
- o_ready=1 only in IDLE; it is registered state, with no combinational path from i_valid.
- i_valid with o_ready=0 is ignored; nothing is queued. Upstream holds i_valid until accepted.
- Changes on i_data after acceptance have no effect on the frame in flight.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: o_tx=1. On accept -> START, starting the cycle after the accepting edge.
  - START: o_tx=0 for exactly CLKS_PER_BIT cycles -> DATA.
  - DATA: o_tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit period; bit index counts 0..7. After bit 7 -> STOP.
  - STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE.
- o_done pulses high for one cycle: the last cycle of STOP, coincident with the transition to IDLE.
- o_busy=1 in START, DATA and STOP.
- o_tx is driven from a register, so it is glitch-free.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps at CLKS_PER_BIT-1.
  - Width $clog2(CLKS_PER_BIT).
  - Reset to 0 on every state change.
- Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles from the first low cycle of o_tx to the end of the stop bit(s).
- Back-to-back: IDLE lasts at least 1 cycle between frames, since o_ready rises in the cycle after o_done. Minimum period between start bits is (9+STOP_BITS)*CLKS_PER_BIT+1 cycles.
- Reset mid-frame: o_tx returns high immediately (async) and the byte is discarded; no o_done pulse. After release the block is in IDLE with o_ready=1.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> o_tx=1, o_ready=1, o_busy=0, o_done=0. Release, then hold i_valid=0 for 50 cycles -> o_tx stays 1 throughout.
- Single byte, CLKS_PER_BIT=4, STOP_BITS=1, i_data=0x41 accepted -> from the next cycle, o_tx bit periods of 4 cycles each read 0,1,0,0,0,0,0,1,0,1. o_done is high on cycle 40 only. o_ready returns 1 the cycle after o_done.
- Back-to-back, CLKS_PER_BIT=4: i_valid held high with 0x55 then 0xAA -> frames 0,1,0,1,0,1,0,1,0,1 and 0,0,1,0,1,0,1,0,1,1. Start bits are 41 cycles apart. Exactly two o_done pulses.
- Ignored request: during a frame, pulse i_valid with 0xFF for 2 cycles while o_ready=0 -> no extra frame. The current frame is unaltered, and changing i_data mid-frame also has no effect.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> o_tx=1 in the same cycle, o_busy=0, no o_done. After release, send 0x00 -> correct frame 0,0,0,0,0,0,0,0,0,1.
- STOP_BITS=2, CLKS_PER_BIT=3, send 0xFF -> o_tx low for 3 cycles, then high for 30 cycles. o_done fires 33 cycles after the first low cycle.
